// File: rtl/rot_pkg.sv
// rot_pkg: definitions shared by the barrel rotator and its decoder.
//   state_t          - decoder FSM states (IDLE, SEARCH)
//   DIR_RIGHT/LEFT   - direction encoding, identical to the rotator's dir
//   rotr1 / rotl1    - single-position rotate of the low w bits of a word
//                      held in a MAX_W-wide container; bits at w and above
//                      are returned as zero.
package rot_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Largest word width the rotate helpers handle.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] rotr1(input logic [MAX_W-1:0] v,
                                             input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W - 1; i++) begin
      if (i < w - 1) r[i] = v[i+1];
    end
    r[w-1] = v[0];
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v,
                                             input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 1; i < MAX_W; i++) begin
      if (i < w) r[i] = v[i-1];
    end
    r[0] = v[w-1];
    return r;
  endfunction

endpackage

// File: rtl/rot_step.sv
// rot_step: combinational one-position rotate of the two search candidates.
//   cr      in  WIDTH  right-going candidate
//   cl      in  WIDTH  left-going candidate
//   cr_next out WIDTH  cr rotated right by one
//   cl_next out WIDTH  cl rotated left by one
module rot_step
  import rot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cr,
  input  logic [WIDTH-1:0] cl,
  output logic [WIDTH-1:0] cr_next,
  output logic [WIDTH-1:0] cl_next
);

  logic [MAX_W-1:0] r_full;
  logic [MAX_W-1:0] l_full;

  always_comb begin
    r_full  = rotr1(MAX_W'(cr), WIDTH);
    l_full  = rotl1(MAX_W'(cl), WIDTH);
    cr_next = r_full[WIDTH-1:0];
    cl_next = l_full[WIDTH-1:0];
  end

  // The helpers always return zero above WIDTH; those bits are dropped.
  if (WIDTH < MAX_W) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^{r_full[MAX_W-1:WIDTH], l_full[MAX_W-1:WIDTH]};
  end

endmodule

// File: rtl/rot_decoder.sv
// rot_decoder: finds the rotation (amount and direction) mapping a onto y.
// One candidate pair (right by k, left by k) is tested per clock for
// k = 0..WIDTH/2, which covers every rotation since left-by-k equals
// right-by-(WIDTH-k). Right is tested before left at each k, so the
// reported result is the minimum-magnitude rotation, ties going right.
//   clk     in  1      rising-edge clock
//   rst_n   in  1      asynchronous active-low reset
//   start   in  1      request; sampled only in IDLE
//   a       in  WIDTH  original word, captured on accept
//   y       in  WIDTH  rotated word, captured on accept
//   busy    out 1      high while searching
//   done    out 1      one-cycle pulse when the result is valid
//   found   out 1      y is a rotation of a (held until next accept)
//   s_out   out SW     rotation amount 0..WIDTH/2
//   dir_out out 1      0 = right, 1 = left
module rot_decoder
  import rot_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [SW-1:0]    s_out,
  output logic             dir_out
);

  localparam logic [SW:0] HALF = (SW+1)'(WIDTH / 2);

  state_t           state, state_n;
  logic [WIDTH-1:0] y_q, y_n;
  logic [WIDTH-1:0] cr, cr_n, cr_rot;
  logic [WIDTH-1:0] cl, cl_n, cl_rot;
  logic [SW:0]      k, k_n;
  logic             done_n, found_n, dir_n;
  logic [SW-1:0]    s_n;

  rot_step #(.WIDTH(WIDTH)) u_step (
    .cr      (cr),
    .cl      (cl),
    .cr_next (cr_rot),
    .cl_next (cl_rot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      y_q     <= '0;
      cr      <= '0;
      cl      <= '0;
      k       <= '0;
      done    <= 1'b0;
      found   <= 1'b0;
      s_out   <= '0;
      dir_out <= DIR_RIGHT;
    end else begin
      state   <= state_n;
      y_q     <= y_n;
      cr      <= cr_n;
      cl      <= cl_n;
      k       <= k_n;
      done    <= done_n;
      found   <= found_n;
      s_out   <= s_n;
      dir_out <= dir_n;
    end
  end

  always_comb begin
    state_n = state;
    y_n     = y_q;
    cr_n    = cr;
    cl_n    = cl;
    k_n     = k;
    done_n  = 1'b0;
    found_n = found;
    s_n     = s_out;
    dir_n   = dir_out;

    unique case (state)
      IDLE: begin
        if (start) begin
          y_n     = y;
          cr_n    = a;
          cl_n    = a;
          k_n     = '0;
          found_n = 1'b0;
          s_n     = '0;
          dir_n   = DIR_RIGHT;
          state_n = SEARCH;
        end
      end
      SEARCH: begin
        if (cr == y_q) begin
          found_n = 1'b1;
          s_n     = k[SW-1:0];
          dir_n   = DIR_RIGHT;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (cl == y_q) begin
          found_n = 1'b1;
          s_n     = k[SW-1:0];
          dir_n   = DIR_LEFT;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (k == HALF) begin
          // Every rotation has been tried without a match.
          found_n = 1'b0;
          s_n     = '0;
          dir_n   = DIR_RIGHT;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cr_n = cr_rot;
          cl_n = cl_rot;
          k_n  = k + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == SEARCH);

endmodule

// File: tb/tb_rot_decoder.sv
module tb_rot_decoder;

  localparam int WIDTH = 8;
  localparam int SW    = 3;
  localparam int LIMIT = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic             found;
  logic [SW-1:0]    s_out;
  logic             dir_out;

  rot_decoder #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .s_out   (s_out),
    .dir_out (dir_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          found;
    logic [SW-1:0] s;
    logic          dir;
    int            lat;
  } exp_t;

  exp_t sbq[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Observed values of the most recent operation.
  logic          o_found, o_dir;
  logic [SW-1:0] o_s;
  int            o_lat, o_busy;
  logic          o_timeout;

  function automatic logic [WIDTH-1:0] rr(input logic [WIDTH-1:0] v, input int k);
    logic [WIDTH-1:0] r;
    r = (v >> k) | (v << (WIDTH - k));
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rl(input logic [WIDTH-1:0] v, input int k);
    logic [WIDTH-1:0] r;
    r = (v << k) | (v >> (WIDTH - k));
    return r;
  endfunction

  // Reference: smallest k, right before left; latency edges = k+1.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] yv);
    exp_t e;
    e.found = 1'b0; e.s = '0; e.dir = 1'b0; e.lat = WIDTH/2 + 1;
    for (int k = 0; k <= WIDTH/2; k++) begin
      if (rr(av, k) == yv) begin
        e.found = 1'b1; e.s = SW'(k); e.dir = 1'b0; e.lat = k + 1;
        return e;
      end
      if (rl(av, k) == yv) begin
        e.found = 1'b1; e.s = SW'(k); e.dir = 1'b1; e.lat = k + 1;
        return e;
      end
    end
    return e;
  endfunction

  // Drives one request from just after an edge and waits (bounded) for done.
  // If busy_start is set, a second start with other data is driven while busy.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] yv,
                        input bit busy_start);
    a = av; y = yv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    o_lat = 0; o_busy = busy ? 1 : 0; o_timeout = 1'b0;
    while (!done && o_lat < LIMIT) begin
      if (busy_start && o_lat == 1) begin
        a = 8'h01; y = 8'h80; start = 1'b1;
      end else begin
        start = 1'b0;
        if (busy_start) begin a = $urandom; y = $urandom; end
      end
      @(posedge clk); #1;
      o_lat++;
      if (busy) o_busy++;
    end
    start = 1'b0;
    o_timeout = !done;
    o_found = found; o_s = s_out; o_dir = dir_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; y = '0;
    #12;
    n_total++;
    if ({busy, done, found, s_out, dir_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b want=0", {busy, done, found, s_out, dir_out});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_result(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      n_total++; n_bad++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = sbq.pop_front();
    n_total++;
    if (o_timeout) begin
      n_bad++;
      $display("FAIL %s_timeout no done within %0d cycles", name, LIMIT);
    end
    n_total++;
    if ({o_found, o_s, o_dir} !== {e.found, e.s, e.dir}) begin
      n_bad++;
      $display("FAIL %s_result got found=%b s=%0d dir=%b want found=%b s=%0d dir=%b",
               name, o_found, o_s, o_dir, e.found, e.s, e.dir);
    end
    n_total++;
    if (o_lat !== e.lat) begin
      n_bad++;
      $display("FAIL %s_latency got=%0d want=%0d", name, o_lat, e.lat);
    end
  endtask

  task automatic test_reset_mid_search();
    a = 8'hB1; y = 8'hB2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, found, s_out, dir_out} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs got=%b want=0", {busy, done, found, s_out, dir_out});
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL midreset_no_done got=%b want=0", done);
      end
      if (i == 2) rst_n = 1'b1;
    end
    sbq.push_back(model(8'hB1, 8'hB1));
    run_op(8'hB1, 8'hB1, 1'b0);
    check_result("identity_after_reset");
    @(posedge clk); #1;
  endtask

  task automatic test_right();
    sbq.push_back(model(8'hB1, 8'h6C));
    run_op(8'hB1, 8'h6C, 1'b0);
    check_result("right_match");
    n_total++;
    if (o_busy !== 3) begin
      n_bad++;
      $display("FAIL right_busy_cycles got=%0d want=3", o_busy);
    end
    // done must drop after one cycle
    @(posedge clk); #1;
    n_total++;
    if (done !== 1'b0 || found !== 1'b1) begin
      n_bad++;
      $display("FAIL done_pulse got done=%b found=%b want done=0 found=1", done, found);
    end
  endtask

  task automatic test_left();
    sbq.push_back(model(8'hB1, 8'h8D));
    run_op(8'hB1, 8'h8D, 1'b0);
    check_result("left_match");
  endtask

  task automatic test_tie();
    sbq.push_back(model(8'h12, 8'h21));
    run_op(8'h12, 8'h21, 1'b0);
    check_result("tie_k4");
  endtask

  task automatic test_back_to_back();
    sbq.push_back(model(8'hB1, 8'hB2));
    run_op(8'hB1, 8'hB2, 1'b0);
    check_result("not_found");
    // run_op returns inside the done cycle, so this start is back-to-back
    sbq.push_back(model(8'h55, 8'hAA));
    run_op(8'h55, 8'hAA, 1'b0);
    check_result("b2b_periodic");
    sbq.push_back(model(8'h00, 8'h00));
    run_op(8'h00, 8'h00, 1'b0);
    check_result("all_zero");
    sbq.push_back(model(8'hFF, 8'hFF));
    run_op(8'hFF, 8'hFF, 1'b0);
    check_result("all_one");
  endtask

  task automatic test_start_while_busy();
    @(posedge clk); #1;
    sbq.push_back(model(8'hB1, 8'h8D));
    run_op(8'hB1, 8'h8D, 1'b1);
    check_result("busy_ignore");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_ignore_idle got done=%b busy=%b want 0 0", done, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] yv;
    for (int av = 0; av < 256; av++) begin
      for (int r = 0; r < WIDTH; r++) begin
        yv = rr(WIDTH'(av), r);
        if (r == 5 && av[0]) yv = $urandom;
        sbq.push_back(model(WIDTH'(av), yv));
        run_op(WIDTH'(av), yv, 1'b0);
        check_result("sweep");
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_search();
    test_right();
    test_left();
    test_tie();
    test_back_to_back();
    test_start_while_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rot_decoder.md
Name: rot_decoder

Overview:
- Inverse of the team's combinational barrel rotator. Given an original word a and a rotated word y, it searches sequentially for the rotation amount and direction that map a onto y.
- Used beside the rotator as a self-check and decode block: rotation-based scramblers, alignment recovery, BIST comparison.
- One candidate rotation pair is evaluated per clock, with a start/busy/done handshake.

Parameters:
- WIDTH, 8, data word width; power of two, at least 4.
- SW, $clog2(WIDTH), width of the shift-amount output (3 when WIDTH=8).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse. Sampled only in IDLE.
- a  in  WIDTH  original word. Captured when start is accepted.
- y  in  WIDTH  rotated word. Captured when start is accepted.
- busy  out  1  high while in SEARCH.
- done  out  1  one-cycle pulse when the result is valid.
- found  out  1  1 if y is a rotation of a. Valid from done, held until next accept.
- s_out  out  SW  rotation amount, 0..WIDTH/2.
- dir_out  out  1  0 = rotate right, 1 = rotate left. Same encoding as the rotator's dir.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, k=0, internal registers cleared.
  - busy=0, done=0, found=0, s_out=0, dir_out=0.
- States: IDLE, SEARCH.
- Registers: a_q, y_q, cr (right candidate), cl (left candidate), k (0..WIDTH/2, SW+1 bits).
- IDLE with start=1 (accept):
  - a_q=a, y_q=y, cr=a, cl=a, k=0.
  - found/s_out/dir_out cleared to 0.
  - Go to SEARCH; busy=1 next cycle.
- SEARCH, each cycle, in priority order:
  1. cr==y_q: found=1, s_out=k, dir_out=0, done=1, go to IDLE.
  2. else cl==y_q: found=1, s_out=k, dir_out=1, done=1, go to IDLE.
  3. else k==WIDTH/2: found=0, s_out=0, dir_out=0, done=1, go to IDLE.
  4. else: cr=rotr1(cr), cl=rotl1(cl), k=k+1.
- Coverage: left by k equals right by WIDTH-k, so k in 0..WIDTH/2 covers all WIDTH rotations.
- Result is always the minimum-magnitude rotation. Ties are broken toward right, then smaller k.
- Latency:
  - With start accepted at edge E0, done is high in the cycle after edge E0+m+1, where m is the matching k.
  - Identity: done 2 cycles after the start edge. Worst case / not found: WIDTH/2+2 cycles.
- Handshake rules:
  - done is registered and pulses for exactly 1 cycle; state is IDLE in that cycle.
  - start in the done cycle is accepted, giving back-to-back operation.
  - start while busy=1 is ignored; the in-flight search is unaffected.
  - Changes on a/y after accept have no effect.
- Degenerate inputs:
  - a=y (including all-0 or all-1) gives found=1, s=0, dir=0.
  - Periodic patterns, e.g. 0x55 to 0xAA, report the smallest k (s=1, dir=0).
- Reset mid-SEARCH aborts immediately to reset values; no done pulse is issued.

Decomposition:
- Shared package rot_pkg:
  - state enum {IDLE, SEARCH}.
  - DIR_RIGHT=1'b0, DIR_LEFT=1'b1 (shared with the rotator).
  - Functions rotr1/rotl1 parameterized on WIDTH.
- One natural sub-module: rot_step, the combinational single-position right/left rotate of cr/cl. Everything else stays flat in rot_decoder.

Test Plan:
- Reset mid-search: a=0xB1, y=0xB2, pulse start, drop rst_n after 2 cycles -> all outputs 0 asynchronously, no done. After release, a fresh start on a=0xB1, y=0xB1 -> done 2 cycles later with found=1, s_out=0, dir_out=0.
- Right match: a=0xB1, y=0x6C (rotr 2) -> found=1, s_out=2, dir_out=0, done 4 cycles after the start edge, busy high for 3 cycles.
- Left match: a=0xB1, y=0x8D (rotl 3) -> found=1, s_out=3, dir_out=1, done 5 cycles after start.
- Tie at k=4: a=0x12, y=0x21 -> found=1, s_out=4, dir_out=0 (right priority), done 6 cycles after start.
- Not found: a=0xB1, y=0xB2 -> found=0, s_out=0, dir_out=0, done 6 cycles after start. Back-to-back start in the done cycle with a=0x55, y=0xAA -> next done reports s_out=1, dir_out=0.
- Start while busy: a=0xB1, y=0x8D accepted, then start with a=0x01, y=0x80 during SEARCH -> ignored, result s_out=3, dir_out=1. Random check: all a and all rotations versus a reference model.
